// File: rtl/mult_div_ctrl_if.sv
// mult_div_ctrl_if: request / result bundle for mult_div_ctrl.
// master issues Start/Op/A/B, slave returns status and Hi/Lo.
interface mult_div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             DivZero;
    logic [2:0]       stateout;

    modport master (
        output Start, Op, A, B,
        input  Busy, Done, Hi, Lo, DivZero, stateout
    );

    modport slave (
        input  Start, Op, A, B,
        output Busy, Done, Hi, Lo, DivZero, stateout
    );
endinterface

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: iterative signed 32x32 multiply / 32/32 divide.
// Define MULT_DIV_DIVZERO_EN to short-circuit divide-by-zero to DONE.
module mult_div_ctrl #(
    parameter int WIDTH = 32
) (
    input logic            clock,
    input logic            reset,
    mult_div_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic               sign_a;
    logic               sign_b;
    logic [1:0]         op;
    logic [5:0]         cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic               accept;
    logic               zero_div;
    logic               last;
`ifdef MULT_DIV_DIVZERO_EN
    logic               dz;
`endif

    // 0x80000000 negates to itself, which reads correctly as 2^31
    assign abs_a = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign abs_b = bus.B[WIDTH-1] ? -bus.B : bus.B;

    assign accept = (state == IDLE) && bus.Start && !bus.Op[1];

`ifdef MULT_DIV_DIVZERO_EN
    assign zero_div = accept && bus.Op[0] && (bus.B == '0);
`else
    assign zero_div = 1'b0;
`endif

    assign last = (cnt == 6'(WIDTH - 1));

    // acc = {partial product, remaining multiplier bits}
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + (acc[0] ? {1'b0, mag_a} : '0);

    // acc = {partial remainder, dividend bits / quotient bits}
    assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, mag_b};
    assign div_ok   = !div_diff[WIDTH];

    assign prod = (sign_a ^ sign_b) ? -acc : acc;

    // Fold operand signs back into the unsigned result
    always_comb begin
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (op[0]) begin
            fix_lo = (sign_a ^ sign_b) ? -acc[WIDTH-1:0]
                                       : acc[WIDTH-1:0];
            fix_hi = sign_a ? -acc[2*WIDTH-1:WIDTH]
                            : acc[2*WIDTH-1:WIDTH];
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and status outputs
    always_comb begin
        state_nx     = state;
        bus.Busy     = (state != IDLE);
        bus.Done     = (state == DONE);
        bus.stateout = state;
`ifdef MULT_DIV_DIVZERO_EN
        bus.DivZero  = (state == DONE) && dz;
`else
        bus.DivZero  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (zero_div)            state_nx = DONE;
                else if (accept && !bus.Op[0]) state_nx = MULT;
                else if (accept)         state_nx = DIV;
            end
            MULT:    if (last) state_nx = FIX;
            DIV:     if (last) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            mag_a  <= '0;
            mag_b  <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            op     <= 2'b00;
            cnt    <= 6'd0;
            acc    <= '0;
            hi     <= '0;
            lo     <= '0;
`ifdef MULT_DIV_DIVZERO_EN
            dz     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        mag_a  <= abs_a;
                        mag_b  <= abs_b;
                        sign_a <= bus.A[WIDTH-1];
                        sign_b <= bus.B[WIDTH-1];
                        op     <= bus.Op;
                        cnt    <= 6'd0;
                        acc    <= bus.Op[0] ? {{WIDTH{1'b0}}, abs_a}
                                            : {{WIDTH{1'b0}}, abs_b};
`ifdef MULT_DIV_DIVZERO_EN
                        dz     <= zero_div;
`endif
                    end
                end
                MULT: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt + 6'd1;
                end
                DIV: begin
                    acc <= {div_ok ? div_diff[WIDTH-1:0]
                                   : div_sh[WIDTH-1:0],
                            acc[WIDTH-2:0], div_ok};
                    cnt <= cnt + 6'd1;
                end
                FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign bus.Hi = hi;
    assign bus.Lo = lo;
endmodule
